// File: rtl/fp_align_shifter.sv
// Two-stage mantissa alignment shifter with guard/round/sticky extraction.
// Optional macro FP_ALIGN_STICKY_CHECK_EN adds an OR-reduction sticky self-check.
module fp_align_shifter #(
  parameter int unsigned SizeMantissa = 23
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [SizeMantissa+1:0]           mantissa,
  input  logic [$clog2(SizeMantissa+1)-1:0] trailing_zeros,
  input  logic [7:0]                        shift_amount,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [SizeMantissa+1:0]           shifted,
  output logic                              guard,
  output logic                              round_bit,
  output logic                              sticky,
  output logic                              sticky_mismatch
);

  localparam int unsigned W   = SizeMantissa + 2;
  localparam int unsigned TzW = $clog2(SizeMantissa + 1);

  logic           s1_valid_q, s1_valid_d;
  logic [W-1:0]   s1_mant_q;
  logic [TzW-1:0] s1_tz_q;
  logic [7:0]     s1_shift_q;
  logic           s2_valid_q, s2_valid_d;
  logic [W-1:0]   s2_shifted_q;
  logic           s2_guard_q, s2_round_q, s2_sticky_q;

  logic           s1_load, s1_advance;
  logic [W+1:0]   ext;
  logic [8:0]     s_ext, tz_ext;
  logic           sticky_tz;

  assign s1_advance = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready   = !s1_valid_q || s1_advance;
  assign s1_load    = in_valid && in_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (s1_load)         s1_valid_d = 1'b1;
    else if (s1_advance) s1_valid_d = 1'b0;
    s2_valid_d = s2_valid_q;
    if (s1_advance)     s2_valid_d = 1'b1;
    else if (out_ready) s2_valid_d = 1'b0;
  end

  // Two extra low bits catch guard and round as they fall off the end.
  assign ext = {s1_mant_q, 2'b00} >> s1_shift_q;

  // Lowest set bit sits at trailing_zeros, so sticky is set once s-3 reaches it.
  always_comb begin
    s_ext     = {1'b0, s1_shift_q};
    tz_ext    = 9'(s1_tz_q);
    sticky_tz = 1'b0;
    if (tz_ext <= 9'(SizeMantissa)) begin
      sticky_tz = (s_ext >= tz_ext + 9'd3);
    end else begin
      sticky_tz = s1_mant_q[W-1] && (s_ext >= 9'(SizeMantissa + 4));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_mant_q  <= '0;
      s1_tz_q    <= '0;
      s1_shift_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_load) begin
        s1_mant_q  <= mantissa;
        s1_tz_q    <= trailing_zeros;
        s1_shift_q <= shift_amount;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q   <= 1'b0;
      s2_shifted_q <= '0;
      s2_guard_q   <= 1'b0;
      s2_round_q   <= 1'b0;
      s2_sticky_q  <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s1_advance) begin
        s2_shifted_q <= ext[W+1:2];
        s2_guard_q   <= ext[1];
        s2_round_q   <= ext[0];
        s2_sticky_q  <= sticky_tz;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign shifted   = s2_shifted_q;
  assign guard     = s2_guard_q;
  assign round_bit = s2_round_q;
  assign sticky    = s2_sticky_q;

`ifdef FP_ALIGN_STICKY_CHECK_EN
  logic [W-1:0] or_mask;
  logic         sticky_or;
  logic         mismatch_q;

  // Mask covers bits [s-3:0]; a shift of s-2 >= W saturates to all ones.
  always_comb begin
    or_mask = '0;
    if (s1_shift_q >= 8'd3) or_mask = ~({W{1'b1}} << (s1_shift_q - 8'd2));
    sticky_or = |(s1_mant_q & or_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_q <= 1'b0;
    end else if (s1_advance) begin
      mismatch_q <= (sticky_or != sticky_tz);
    end
  end

  assign sticky_mismatch = s2_valid_q && mismatch_q;
`else
  assign sticky_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_fp_align_shifter.sv
// Directed and randomized checks of fp_align_shifter at SizeMantissa=23.
module tb_fp_align_shifter;

  localparam int unsigned SM = 23;
  localparam int unsigned W  = SM + 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] mantissa = '0;
  logic [4:0]   trailing_zeros = '0;
  logic [7:0]   shift_amount = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] shifted;
  logic         guard, round_bit, sticky, sticky_mismatch;

  int n_assert = 0;
  int n_fail   = 0;

  fp_align_shifter #(.SizeMantissa(SM)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .mantissa       (mantissa),
    .trailing_zeros (trailing_zeros),
    .shift_amount   (shift_amount),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .shifted        (shifted),
    .guard          (guard),
    .round_bit      (round_bit),
    .sticky         (sticky),
    .sticky_mismatch(sticky_mismatch)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [W-1:0] m, input logic [4:0] tz, input logic [7:0] s);
    mantissa       = m;
    trailing_zeros = tz;
    shift_amount   = s;
    in_valid       = 1'b1;
  endtask

  task automatic check_out(input string tag, input logic [W-1:0] sh, input logic g,
                           input logic r, input logic st);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".shifted"}, 32'(shifted), 32'(sh));
    check({tag, ".grs"}, {29'd0, guard, round_bit, sticky}, {29'd0, g, r, st});
    check({tag, ".mismatch"}, 32'(sticky_mismatch), 32'd0);
  endtask

  // Called just after a negedge with the pipeline empty; returns after the result is checked.
  task automatic run_vec(input string tag, input logic [W-1:0] m, input logic [4:0] tz,
                         input logic [7:0] s, input logic [W-1:0] sh, input logic g,
                         input logic r, input logic st);
    out_ready = 1'b1;
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    drive(m, tz, s);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check_out(tag, sh, g, r, st);
  endtask

  function automatic logic [4:0] count_tz(input logic [W-1:0] m);
    for (int i = 0; i <= int'(SM); i++) if (m[i]) return 5'(i);
    return 5'(SM + 1);
  endfunction

  function automatic logic bit_at(input logic [W-1:0] m, input int idx);
    if (idx < 0 || idx >= int'(W)) return 1'b0;
    return m[idx];
  endfunction

  function automatic logic or_sticky(input logic [W-1:0] m, input int s);
    logic acc = 1'b0;
    for (int i = 0; i < int'(W); i++) if (i <= s - 3) acc |= m[i];
    return acc;
  endfunction

  initial begin
    logic [31:0]  r32, mask32;
    logic [W-1:0] rm;
    int           rs;

    // Reset state
    #2;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.shifted", 32'(shifted), 32'd0);
    check("rst.grs", {29'd0, guard, round_bit, sticky}, 32'd0);
    check("rst.mismatch", 32'(sticky_mismatch), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.in_ready", 32'(in_ready), 32'd1);

    // Directed vectors
    run_vec("v_s5",   25'h1000008, 5'd3,  8'd5,  25'h0080000, 1'b0, 1'b1, 1'b0);
    run_vec("v_s4",   25'h1000001, 5'd0,  8'd4,  25'h0100000, 1'b0, 1'b0, 1'b1);
    run_vec("v_s0",   25'h1ABCDEF, 5'd0,  8'd0,  25'h1ABCDEF, 1'b0, 1'b0, 1'b0);
    run_vec("v_s40",  25'h1000000, 5'd24, 8'd40, 25'h0000000, 1'b0, 1'b0, 1'b1);
    run_vec("v_s1",   25'h1FFFFFF, 5'd0,  8'd1,  25'h0FFFFFF, 1'b1, 1'b0, 1'b0);
    run_vec("v_s2",   25'h1FFFFFF, 5'd0,  8'd2,  25'h07FFFFF, 1'b1, 1'b1, 1'b0);
    run_vec("v_s3",   25'h1FFFFFF, 5'd0,  8'd3,  25'h03FFFFF, 1'b1, 1'b1, 1'b1);
    run_vec("v_s25",  25'h1000000, 5'd24, 8'd25, 25'h0000000, 1'b1, 1'b0, 1'b0);
    run_vec("v_s26",  25'h1000000, 5'd24, 8'd26, 25'h0000000, 1'b0, 1'b1, 1'b0);
    run_vec("v_s27",  25'h1000000, 5'd24, 8'd27, 25'h0000000, 1'b0, 1'b0, 1'b1);
    run_vec("v_zero", 25'h0000000, 5'd24, 8'd10, 25'h0000000, 1'b0, 1'b0, 1'b0);
    run_vec("v_s255", 25'h0800000, 5'd23, 8'd255, 25'h0000000, 1'b0, 1'b0, 1'b1);

    // Back-to-back throughput
    out_ready = 1'b1;
    drive(25'h1000008, 5'd3, 8'd5);
    @(negedge clk);
    drive(25'h1000001, 5'd0, 8'd4);
    @(negedge clk);
    check_out("tp_a", 25'h0080000, 1'b0, 1'b1, 1'b0);
    drive(25'h1ABCDEF, 5'd0, 8'd0);
    @(negedge clk);
    in_valid = 1'b0;
    check_out("tp_b", 25'h0100000, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check_out("tp_c", 25'h1ABCDEF, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("tp.drained", 32'(out_valid), 32'd0);

    // Backpressure: two accepted, third stalls, first held
    out_ready = 1'b0;
    drive(25'h1000008, 5'd3, 8'd5);
    @(negedge clk);
    drive(25'h1000001, 5'd0, 8'd4);
    check("bp.ready_b", 32'(in_ready), 32'd1);
    @(negedge clk);
    drive(25'h1ABCDEF, 5'd0, 8'd0);
    check("bp.stall", 32'(in_ready), 32'd0);
    check_out("bp.hold0", 25'h0080000, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("bp.stall1", 32'(in_ready), 32'd0);
    check_out("bp.hold1", 25'h0080000, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check_out("bp.hold2", 25'h0080000, 1'b0, 1'b1, 1'b0);
    out_ready = 1'b1;
    #1;
    check("bp.release", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check_out("bp.b", 25'h0100000, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check_out("bp.c", 25'h1ABCDEF, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("bp.drained", 32'(out_valid), 32'd0);

    // Reset mid-operation with both stages full
    out_ready = 1'b0;
    drive(25'h1FFFFFF, 5'd0, 8'd1);
    @(negedge clk);
    drive(25'h1FFFFFF, 5'd0, 8'd2);
    @(negedge clk);
    in_valid = 1'b0;
    check("mr.full", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mr.out_valid", 32'(out_valid), 32'd0);
    check("mr.shifted", 32'(shifted), 32'd0);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("mr.in_ready", 32'(in_ready), 32'd1);
    check("mr.stale0", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("mr.stale1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("mr.stale2", 32'(out_valid), 32'd0);

    // Random vectors against a bit-level reference
    for (int n = 0; n < 300; n++) begin
      r32 = $urandom;
      rm  = r32[W-1:0];
      if ($urandom_range(0, 2) == 0) begin
        mask32 = (32'h1 << $urandom_range(0, 25)) - 32'h1;
        rm     = rm & ~mask32[W-1:0];
      end
      rs = $urandom_range(0, 40);
      run_vec("rnd", rm, count_tz(rm), 8'(rs), rm >> rs, bit_at(rm, rs - 1),
              bit_at(rm, rs - 2), (rs >= 3) ? or_sticky(rm, rs) : 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
